vga_timing: RTL and testbench
=============================

# vga_timing

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Supplies the pixel coordinates `x`, `y`, the `visible` window and the `hsync`/`vsync` pulses to the downstream screen renderers, such as the Pong playfield renderer. Also emits a one-cycle `vblank_start` strobe that game logic uses to advance paddle and ball state once per frame.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE_LOW`, 1, 1 = sync pulses driven low when active, 0 = high

Ports:
- `clk` in 1: pixel clock, 25 MHz. Single clock domain; one clock, all logic on its rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `x` out 10: horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800).
- `y` out 10: vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525).
- `visible` out 1: high when x < H_VISIBLE and y < V_VISIBLE.
- `hsync` out 1: horizontal sync, polarity per SYNC_ACTIVE_LOW.
- `vsync` out 1: vertical sync, polarity per SYNC_ACTIVE_LOW.
- `vblank_start` out 1: one-cycle strobe at x = 0, y = V_VISIBLE.

## Operation
- Horizontal counter `hcnt` increments every clock.
  - At H_TOTAL-1 it wraps to 0.
  - On that wrap the vertical counter `vcnt` increments.
- `vcnt` wraps to 0 when it is V_TOTAL-1 and `hcnt` wraps.
- Outputs:
  - `x` = `hcnt` and `y` = `vcnt`; both are registered counters.
  - Coordinates keep counting through blanking. Consumers must qualify with `visible`.
- Sync windows:
  - `hsync` is active for hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656, 752).
  - `vsync` is active for vcnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490, 492), across the full line width.
- `vblank_start` is high for exactly the one clock where (x, y) = (0, V_VISIBLE).
- Width rules:
  - H_TOTAL and V_TOTAL must be ≤ 1024. This is an elaboration-time assertion.
  - Comparisons use 10-bit unsigned arithmetic. No signed math.

## Timing
- `visible`, `hsync`, `vsync` and `vblank_start` are registers.
  - Each is decoded from the *next* counter values, so on every cycle it matches the `x`/`y` presented in that cycle. There is zero-cycle skew between coordinates and qualifiers.
  - None of these outputs is combinational from the counters, so sync outputs are glitch-free.
- Reset values (asynchronous, while `reset_n` = 0):
  - `x` = 0, `y` = 0, `visible` = 1
  - `hsync` = `vsync` = inactive (1 when SYNC_ACTIVE_LOW = 1)
  - `vblank_start` = 0
- First clock after `reset_n` deasserts: `x` = 1, `y` = 0.
- Periods: line = 800 clocks; frame = 420 000 clocks; visible pixels per frame = 307 200.
- Reset asserted mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge.
  - No `vblank_start` is issued for the aborted frame.
  - Counting restarts from (0, 0).
- Simultaneous horizontal and vertical wrap at (799, 524): the next cycle is (0, 0) with `visible` = 1.

## Structure
- Shared package `vga_pkg`:
  - default timing localparams (640/16/96/48, 480/10/2/33)
  - derived H_TOTAL and V_TOTAL
  - the 10-bit `coord_t` typedef
- The renderers import `vga_pkg` for HRES/VRES instead of redefining them.
- One sub-module is natural: `vga_axis_counter`.
  - Parameters: VISIBLE, FRONT, SYNC, BACK.
  - Inputs: `clk`, `reset_n`, `en`.
  - Outputs: `count`, `wrap`, `active`, `sync`. `active` and `sync` are registered next-value decodes.
  - Instantiated twice: horizontal with `en` = 1, and vertical with `en` = horizontal `wrap`.
- Top level combines the two into `visible` and `vblank_start`.

## Test plan
- **Reset values:** hold `reset_n` = 0 for 5 clocks → x = 0, y = 0, visible = 1, hsync = vsync = 1, vblank_start = 0. Release reset → x = 1 on the next clock.
- **hsync window:** hsync falls on the cycle where x = 656, stays low for exactly 96 clocks, and rises at x = 752. visible = 0 for x in 640..799.
- **Line and frame wrap:**
  - (799, 10) → (0, 11)
  - (799, 524) → (0, 0)
  - consecutive (0, 0) occurrences exactly 420 000 clocks apart
- **vsync and vblank:**
  - vblank_start pulses exactly once per frame, at (0, 480), for 1 clock.
  - vsync is low from (0, 490) through (799, 491), i.e. 1600 clocks.
- **Reset mid-frame:** assert `reset_n` = 0 asynchronously, between clock edges, at (300, 200) → outputs reach reset values before the next edge. After release, no vblank_start occurs until (0, 480) of the new frame.
- **Coverage count:** over 3 full frames, count the cycles with visible = 1 → 307 200 per frame. SYNC_ACTIVE_LOW = 0 build → hsync/vsync polarity inverted, with identical windows.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 VGA timing defaults and coordinate type
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Renderers size their playfields from these rather than restating 640/480.
  localparam int HRES = H_VISIBLE_DEF;
  localparam int VRES = V_VISIBLE_DEF;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered
// active-window and sync-window flags decoded from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               active,
  output logic               sync
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

  localparam coord_t C_LAST       = coord_t'(TOTAL - 1);
  localparam coord_t C_VISIBLE    = coord_t'(VISIBLE);
  localparam coord_t C_SYNC_FIRST = coord_t'(VISIBLE + FRONT);
  localparam coord_t C_SYNC_LAST  = coord_t'(VISIBLE + FRONT + SYNC - 1);

  if (TOTAL > 1024) begin : g_total_check
    $error("vga_axis_counter: TOTAL %0d exceeds 10-bit coordinate range", TOTAL);
  end

  coord_t r_count;
  logic   r_active;
  logic   r_sync;
  coord_t w_count_next;
  logic   w_last;

  assign w_last = (r_count == C_LAST);
  assign wrap   = en & w_last;

  always_comb begin
    w_count_next = r_count;
    if (en) begin
      w_count_next = w_last ? '0 : r_count + 1'b1;
    end
  end

  // Flags follow the next count so they line up with count in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_active <= 1'b1;
      r_sync   <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_active <= (w_count_next < C_VISIBLE);
      r_sync   <= (w_count_next >= C_SYNC_FIRST) && (w_count_next <= C_SYNC_LAST);
    end
  end

  assign count  = r_count;
  assign active = r_active;
  assign sync   = r_sync;

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing: pixel coordinates, visible window,
// sync pulses and a once-per-frame vblank_start strobe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE       = H_VISIBLE_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_VISIBLE       = V_VISIBLE_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank_start
);

  localparam coord_t C_V_LAST_VISIBLE = coord_t'(V_VISIBLE - 1);

  coord_t w_h_count;
  coord_t w_v_count;
  logic   w_h_wrap;
  logic   w_h_active;
  logic   w_v_active;
  logic   w_h_sync;
  logic   w_v_sync;
  logic   w_unused_v_wrap;
  logic   r_vblank_start;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .count   (w_h_count),
    .wrap    (w_h_wrap),
    .active  (w_h_active),
    .sync    (w_h_sync)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_h_wrap),
    .count   (w_v_count),
    .wrap    (w_unused_v_wrap),
    .active  (w_v_active),
    .sync    (w_v_sync)
  );

  // The next cycle is (0, V_VISIBLE) exactly when the line wraps on the last visible row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank_start <= 1'b0;
    end else begin
      r_vblank_start <= w_h_wrap && (w_v_count == C_V_LAST_VISIBLE);
    end
  end

  assign x            = w_h_count;
  assign y            = w_v_count;
  assign visible      = w_h_active & w_v_active;
  assign hsync        = w_h_sync ^ SYNC_ACTIVE_LOW;
  assign vsync        = w_v_sync ^ SYNC_ACTIVE_LOW;
  assign vblank_start = r_vblank_start;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing (default 640x480
// active-low build plus a reduced-size active-high build for full-frame checks).
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       vb;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic [9:0] x1, y1, x2, y2;
  logic       vis1, hs1, vs1, vb1;
  logic       vis2, hs2, vs2, vb2;

  int n_checks = 0;
  int n_fail   = 0;
  int k1       = 0;
  int k2       = 0;
  bit run_cmp  = 1'b0;

  vga_timing #(
    .SYNC_ACTIVE_LOW (1'b1)
  ) dut1 (
    .clk          (clk),
    .reset_n      (rst1_n),
    .x            (x1),
    .y            (y1),
    .visible      (vis1),
    .hsync        (hs1),
    .vsync        (vs1),
    .vblank_start (vb1)
  );

  vga_timing #(
    .H_VISIBLE       (16),
    .H_FRONT         (2),
    .H_SYNC          (4),
    .H_BACK          (3),
    .V_VISIBLE       (12),
    .V_FRONT         (2),
    .V_SYNC          (2),
    .V_BACK          (3),
    .SYNC_ACTIVE_LOW (1'b0)
  ) dut2 (
    .clk          (clk),
    .reset_n      (rst2_n),
    .x            (x2),
    .y            (y2),
    .visible      (vis2),
    .hsync        (hs2),
    .vsync        (vs2),
    .vblank_start (vb2)
  );

  // Clocks elapsed since each DUT last left reset; the model is a pure function of it.
  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) k1 <= 0;
    else         k1 <= k1 + 1;
  end

  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) k2 <= 0;
    else         k2 <= k2 + 1;
  end

  function automatic obs_t model(input int k, input int hvis, input int hfp, input int hsw,
                                 input int hbp, input int vvis, input int vfp, input int vsw,
                                 input int vbp, input bit act_low);
    obs_t o;
    int ht, vt, px, py;
    ht    = hvis + hfp + hsw + hbp;
    vt    = vvis + vfp + vsw + vbp;
    px    = k % ht;
    py    = (k / ht) % vt;
    o.x   = 10'(px);
    o.y   = 10'(py);
    o.vis = (px < hvis) && (py < vvis);
    o.hs  = ((px >= hvis + hfp) && (px < hvis + hfp + hsw)) ^ act_low;
    o.vs  = ((py >= vvis + vfp) && (py < vvis + vfp + vsw)) ^ act_low;
    o.vb  = (px == 0) && (py == vvis);
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d vis=%b hs=%b vs=%b vb=%b, expected x=%0d y=%0d vis=%b hs=%b vs=%b vb=%b (t=%0t)",
               name, a.x, a.y, a.vis, a.hs, a.vs, a.vb, e.x, e.y, e.vis, e.hs, e.vs, e.vb, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk_obs("stream_dut1", {x1, y1, vis1, hs1, vs1, vb1},
              model(k1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
      chk_obs("stream_dut2", {x2, y2, vis2, hs2, vs2, vb2},
              model(k2, 16, 2, 4, 3, 12, 2, 2, 3, 1'b0));
    end
  end

  task automatic wait_k(input int which, input int target);
    int budget;
    budget = 20000;
    while (((which == 1) ? k1 : k2) != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (((which == 1) ? k1 : k2) != target)
      chk($sformatf("wait_k%0d_timeout", which), (which == 1) ? k1 : k2, target);
  endtask

  task automatic dut1_seq();
    int lows;
    @(negedge clk);
    chk("first_x1", int'(x1), 1);
    chk("first_y1", int'(y1), 0);
    wait_k(1, 639);  chk("vis1_x639", int'(vis1), 1);
    wait_k(1, 640);  chk("vis1_x640", int'(vis1), 0);
    wait_k(1, 655);  chk("hs1_x655", int'(hs1), 1);
    wait_k(1, 656);  chk("hs1_x656", int'(hs1), 0);
    wait_k(1, 751);  chk("hs1_x751", int'(hs1), 0);
    wait_k(1, 752);  chk("hs1_x752", int'(hs1), 1);
    wait_k(1, 799);  chk("x1_799", int'(x1), 799);
    chk("vis1_x799", int'(vis1), 0);
    wait_k(1, 800);
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hs1) lows++;
      @(negedge clk);
    end
    chk("hs1_low_clocks", lows, 96);
    wait_k(1, 8799); chk("x1_799_y10", int'(x1), 799); chk("y1_10", int'(y1), 10);
    wait_k(1, 8800); chk("x1_0_y11", int'(x1), 0);     chk("y1_11", int'(y1), 11);
    wait_k(1, 9900); chk("x1_300", int'(x1), 300);     chk("y1_12", int'(y1), 12);
    #2 rst1_n = 1'b0;
    #1;
    chk("async_rst_x1", int'(x1), 0);
    chk("async_rst_y1", int'(y1), 0);
    chk("async_rst_vis1", int'(vis1), 1);
    chk("async_rst_hs1", int'(hs1), 1);
    chk("async_rst_vs1", int'(vs1), 1);
    chk("async_rst_vb1", int'(vb1), 0);
    repeat (2) @(negedge clk);
    #1 rst1_n = 1'b1;
    @(negedge clk);
    chk("restart_x1", int'(x1), 1);
    chk("restart_y1", int'(y1), 0);
  endtask

  task automatic dut2_seq();
    int vis_n, vb_n, vs_n, hs_n, last00;
    vis_n  = 0;
    vb_n   = 0;
    vs_n   = 0;
    hs_n   = 0;
    last00 = -1;
    for (int i = 1; i <= 1425; i++) begin
      @(negedge clk);
      if (vis2) vis_n++;
      if (vb2)  vb_n++;
      if (vs2)  vs_n++;
      if (hs2)  hs_n++;
      if (x2 == 10'd0 && y2 == 10'd0) begin
        if (last00 >= 0) chk("frame_period2", i - last00, 475);
        last00 = i;
      end
      case (i)
        300: chk("vb2_at_0_12", int'(vb2), 1);
        301: chk("vb2_at_1_12", int'(vb2), 0);
        349: chk("vs2_at_24_13", int'(vs2), 0);
        350: chk("vs2_at_0_14", int'(vs2), 1);
        399: chk("vs2_at_24_15", int'(vs2), 1);
        400: chk("vs2_at_0_16", int'(vs2), 0);
        474: begin chk("x2_24", int'(x2), 24); chk("y2_18", int'(y2), 18); end
        475: begin chk("x2_wrap", int'(x2), 0); chk("y2_wrap", int'(y2), 0);
                   chk("vis2_wrap", int'(vis2), 1); end
        default: ;
      endcase
    end
    chk("visible2_3frames", vis_n, 576);
    chk("vblank2_3frames", vb_n, 3);
    chk("vsync2_3frames", vs_n, 150);
    chk("hsync2_3frames", hs_n, 228);

    repeat (5) begin
      int d, n;
      d = $urandom_range(20, 700);
      repeat (d) @(negedge clk);
      #($urandom_range(1, 3)) rst2_n = 1'b0;
      #1;
      chk("async_rst_x2", int'(x2), 0);
      chk("async_rst_y2", int'(y2), 0);
      chk("async_rst_vis2", int'(vis2), 1);
      chk("async_rst_hs2", int'(hs2), 0);
      chk("async_rst_vs2", int'(vs2), 0);
      chk("async_rst_vb2", int'(vb2), 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1 rst2_n = 1'b1;
      n = 0;
      while (!vb2 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("first_vblank2_after_reset", n, 300);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_x1", int'(x1), 0);
    chk("rst_y1", int'(y1), 0);
    chk("rst_vis1", int'(vis1), 1);
    chk("rst_hs1", int'(hs1), 1);
    chk("rst_vs1", int'(vs1), 1);
    chk("rst_vb1", int'(vb1), 0);
    chk("rst_x2", int'(x2), 0);
    chk("rst_vis2", int'(vis2), 1);
    chk("rst_hs2", int'(hs2), 0);
    chk("rst_vs2", int'(vs2), 0);
    run_cmp = 1'b1;
    #1;
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    fork
      dut1_seq();
      dut2_seq();
    join
    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
